pacman_score_keeper: RTL

Game-state and scoring stage between the movement/ghost logic and the top-level display path. It consumes single-cycle event pulses (pellet eaten, power pellet eaten, ghost contact) and maintains:
- a 4-digit packed-BCD score, driven straight onto the seven-segment digits;
- the remaining-pellet and lives counters;
- the frightened-mode timer.

It produces the game's win and lose outcome flags, which the movement and ghost blocks consume.

---
 rtl/pacman_score_keeper_if.sv | 27 ++
 rtl/pacman_score_keeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pacman_score_keeper_if.sv
// rtl/pacman_score_keeper_if.sv - event and status bundle between game logic and the score keeper
interface pacman_score_keeper_if;
  logic        start;
  logic        ack;
  logic        tick;
  logic        pellet;
  logic        power;
  logic        ghost_hit;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        frightened;
  logic        ghost_eaten;
  logic        respawn;
  logic        win;
  logic        lose;
  logic        playing;

  modport master (
    output start, ack, tick, pellet, power, ghost_hit,
    input  score, lives, frightened, ghost_eaten, respawn, win, lose, playing
  );

  modport slave (
    input  start, ack, tick, pellet, power, ghost_hit,
    output score, lives, frightened, ghost_eaten, respawn, win, lose, playing
  );
endinterface

// File: rtl/pacman_score_keeper.sv
// rtl/pacman_score_keeper.sv - Pac-Man score, lives, pellet and frightened-timer keeper (optional PACMAN_EXTRA_LIFE_EN)
module pacman_score_keeper #(
  parameter int NUM_PELLETS = 240,
  parameter int START_LIVES = 3,
  parameter int POWER_TICKS = 300
) (
  input  logic             clk,
  input  logic             reset,
  pacman_score_keeper_if.slave game
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;
  localparam logic [1:0] ST_LOSE = 2'd3;

  localparam int PW_RAW = $clog2(NUM_PELLETS + 1);
  localparam int PW     = (PW_RAW < 2) ? 2 : PW_RAW;
  localparam int TW_RAW = $clog2(POWER_TICKS + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [PW-1:0] PELLETS_INIT = PW'(NUM_PELLETS);
  localparam logic [TW-1:0] TICKS_INIT   = TW'(POWER_TICKS);
  localparam logic [2:0]    LIVES_INIT   = 3'(START_LIVES);

  logic [1:0]    state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [2:0]    lives_q, lives_d;
  logic [PW-1:0] pellets_q, pellets_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          frightened_q;
  logic          ghost_eaten_q;
  logic          respawn_q, respawn_d;
  logic          win_q, lose_q, playing_q;

  logic          in_play;
  logic          eat;
  logic          lethal;
  logic          won;
  logic          award;
  logic [1:0]    consumed;
  logic [3:0]    tens_inc;
  logic [15:0]   inc;
  logic [16:0]   sum;
  logic [15:0]   score_sat;
  logic [PW-1:0] pellets_rem;

`ifdef PACMAN_EXTRA_LIFE_EN
  logic          awarded_q, awarded_d;
`endif

  // Digit-wise decimal add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  d;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return {c, r};
  endfunction

  always_comb begin
    in_play     = (state_q == ST_PLAY);
    eat         = in_play & game.ghost_hit & frightened_q;
    lethal      = in_play & game.ghost_hit & ~frightened_q;
    consumed    = {1'b0, game.pellet} + {1'b0, game.power};
    tens_inc    = (game.pellet ? 4'd1 : 4'd0) + (game.power ? 4'd5 : 4'd0);
    inc         = {4'h0, (eat ? 4'h2 : 4'h0), tens_inc, 4'h0};
    sum         = bcd_add(score_q, inc);
    score_sat   = sum[16] ? 16'h9999 : sum[15:0];
    pellets_rem = (pellets_q > PW'(consumed)) ? (pellets_q - PW'(consumed)) : '0;
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    pellets_d = pellets_q;
    timer_d   = timer_q;
    respawn_d = 1'b0;
    won       = 1'b0;
    award     = 1'b0;
`ifdef PACMAN_EXTRA_LIFE_EN
    awarded_d = awarded_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (game.start) begin
          state_d   = ST_PLAY;
          score_d   = 16'h0000;
          lives_d   = LIVES_INIT;
          pellets_d = PELLETS_INIT;
          timer_d   = '0;
`ifdef PACMAN_EXTRA_LIFE_EN
          awarded_d = 1'b0;
`endif
        end
      end

      ST_PLAY: begin
        score_d   = score_sat;
        pellets_d = pellets_rem;
        won       = (pellets_rem == '0);
`ifdef PACMAN_EXTRA_LIFE_EN
        award = ~awarded_q & (score_q[15:12] == 4'h0) & (score_sat[15:12] != 4'h0);
        if (award) begin
          awarded_d = 1'b1;
        end
`endif
        // Clearing the last pellet outranks a simultaneous lethal hit.
        if (lethal && !won) begin
          timer_d = '0;
          if (award) begin
            respawn_d = 1'b1;
          end else if (lives_q > 3'd1) begin
            lives_d   = lives_q - 3'd1;
            respawn_d = 1'b1;
          end else begin
            lives_d = 3'd0;
            state_d = ST_LOSE;
          end
        end else begin
          if (award) begin
            lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
          end
          if (game.power) begin
            timer_d = TICKS_INIT;
          end else if (game.tick && timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end
        end
        if (won) begin
          state_d = ST_WIN;
        end
      end

      default: begin
        if (game.ack) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      score_q       <= 16'h0000;
      lives_q       <= LIVES_INIT;
      pellets_q     <= PELLETS_INIT;
      timer_q       <= '0;
      frightened_q  <= 1'b0;
      ghost_eaten_q <= 1'b0;
      respawn_q     <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      pellets_q     <= pellets_d;
      timer_q       <= timer_d;
      frightened_q  <= (timer_d != '0);
      ghost_eaten_q <= eat;
      respawn_q     <= respawn_d;
      win_q         <= (state_d == ST_WIN);
      lose_q        <= (state_d == ST_LOSE);
      playing_q     <= (state_d == ST_PLAY);
    end
  end

`ifdef PACMAN_EXTRA_LIFE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      awarded_q <= 1'b0;
    end else begin
      awarded_q <= awarded_d;
    end
  end
`endif

  assign game.score       = score_q;
  assign game.lives       = lives_q;
  assign game.frightened  = frightened_q;
  assign game.ghost_eaten = ghost_eaten_q;
  assign game.respawn     = respawn_q;
  assign game.win         = win_q;
  assign game.lose        = lose_q;
  assign game.playing     = playing_q;

endmodule
